cp0_exc_ctrl: RTL and testbench

CP0_EXC_CTRL -- requirements
Module: cp0_exc_ctrl

---
 rtl/cp0_exc_ctrl_if.sv | 39 +++
 rtl/cp0_exc_ctrl.sv | 163 ++++++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_exc_ctrl_if.sv
// Commit-stage to CP0 bus: exception/ERET/interrupt inputs, MTC0/MFC0 ports,
// and the redirect and live-register outputs.
interface cp0_exc_ctrl_if #(
  parameter int NUM_HW_INT = 5
);
  logic                  valid;
  logic                  exc_valid;
  logic [4:0]            exc_code;
  logic [31:0]           exc_pc;
  logic [31:0]           exc_badvaddr;
  logic                  exc_bd;
  logic                  eret;
  logic [31:0]           cur_pc;
  logic                  cur_bd;
  logic [NUM_HW_INT-1:0] hw_int;
  logic                  wen;
  logic [4:0]            waddr;
  logic [31:0]           wdata;
  logic [4:0]            raddr;
  logic [31:0]           rdata;
  logic                  flush;
  logic [31:0]           flush_pc;
  logic                  int_pending;
  logic [31:0]           status;
  logic [31:0]           cause;
  logic [31:0]           epc;

  modport master (
    output valid, exc_valid, exc_code, exc_pc, exc_badvaddr, exc_bd, eret,
           cur_pc, cur_bd, hw_int, wen, waddr, wdata, raddr,
    input  rdata, flush, flush_pc, int_pending, status, cause, epc
  );

  modport slave (
    input  valid, exc_valid, exc_code, exc_pc, exc_badvaddr, exc_bd, eret,
           cur_pc, cur_bd, hw_int, wen, waddr, wdata, raddr,
    output rdata, flush, flush_pc, int_pending, status, cause, epc
  );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// MIPS-style CP0 exception controller: Status/Cause/EPC/BadVAddr/Count/Compare,
// commit-stage exception, interrupt and ERET handling with pipeline redirect.
module cp0_exc_ctrl #(
  parameter int          NUM_HW_INT = 5,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input logic           clk,
  input logic           resetn,
  cp0_exc_ctrl_if.slave bus
);

  localparam logic [1:0] PRESC_LAST = 2'(COUNT_DIV - 1);

  logic [NUM_HW_INT-1:0] r_sync1;
  logic [NUM_HW_INT-1:0] r_sync2;
  logic [1:0]            r_presc;
  logic [31:0]           r_count;
  logic [31:0]           r_compare;
  logic [31:0]           r_epc;
  logic [31:0]           r_badvaddr;
  logic [7:0]            r_im;
  logic                  r_exl;
  logic                  r_ie;
  logic [1:0]            r_ipsw;
  logic                  r_bd;
  logic                  r_ti;
  logic [4:0]            r_exccode;

  logic [4:0]  w_hwip;
  logic [7:0]  w_ip;
  logic [31:0] w_status;
  logic [31:0] w_cause;
  logic        w_int_pending;
  logic        w_take_exc;
  logic        w_take_int;
  logic        w_take_eret;
  logic        w_mtc0;
  logic        w_wr_count;
  logic        w_wr_compare;
  logic        w_tick;
  logic        w_match;

  always_comb begin
    w_hwip = '0;
    for (int i = 0; i < NUM_HW_INT; i++) w_hwip[i] = r_sync2[i];
  end

  assign w_ip          = {r_ti, w_hwip, r_ipsw};
  assign w_status      = {9'd0, 1'b1, 6'd0, r_im, 6'd0, r_exl, r_ie};
  assign w_cause       = {r_bd, r_ti, 14'd0, w_ip, 1'b0, r_exccode, 2'b00};
  assign w_int_pending = r_ie & ~r_exl & (|(w_ip & r_im));

  // Strict priority: exception > interrupt > ERET > MTC0, all gated by valid.
  assign w_take_exc   = bus.valid & bus.exc_valid;
  assign w_take_int   = bus.valid & ~bus.exc_valid & w_int_pending;
  assign w_take_eret  = bus.valid & ~bus.exc_valid & ~w_int_pending & bus.eret;
  assign w_mtc0       = bus.valid & ~bus.exc_valid & ~w_int_pending & ~bus.eret & bus.wen;
  assign w_wr_count   = w_mtc0 && (bus.waddr == 5'd9);
  assign w_wr_compare = w_mtc0 && (bus.waddr == 5'd11);
  assign w_tick       = (r_presc == PRESC_LAST);
  assign w_match      = (r_count == r_compare);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.hw_int;
      r_sync2 <= r_sync1;
    end
  end

  // Free-running timer; an MTC0 Count restarts the prescaler.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
      r_presc <= '0;
    end else if (w_wr_count) begin
      r_count <= bus.wdata;
      r_presc <= '0;
    end else if (w_tick) begin
      r_count <= r_count + 32'd1;
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 2'd1;
    end
  end

  // TI is sticky until software rewrites Compare; the rewrite beats a new match.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_compare <= '0;
      r_ti      <= 1'b0;
    end else if (w_wr_compare) begin
      r_compare <= bus.wdata;
      r_ti      <= 1'b0;
    end else if (w_match) begin
      r_ti      <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_epc      <= '0;
      r_badvaddr <= '0;
      r_im       <= '0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_ipsw     <= '0;
      r_bd       <= 1'b0;
      r_exccode  <= '0;
    end else if (w_take_exc) begin
      r_exl     <= 1'b1;
      r_exccode <= bus.exc_code;
      // Nested exceptions keep the EPC/BD of the original fault.
      if (!r_exl) begin
        r_epc <= bus.exc_bd ? (bus.exc_pc - 32'd4) : bus.exc_pc;
        r_bd  <= bus.exc_bd;
      end
      if (bus.exc_code == 5'd4 || bus.exc_code == 5'd5) r_badvaddr <= bus.exc_badvaddr;
    end else if (w_take_int) begin
      r_exl     <= 1'b1;
      r_exccode <= 5'd0;
      r_epc     <= bus.cur_bd ? (bus.cur_pc - 32'd4) : bus.cur_pc;
      r_bd      <= bus.cur_bd;
    end else if (w_take_eret) begin
      r_exl <= 1'b0;
    end else if (w_mtc0) begin
      case (bus.waddr)
        5'd12: begin
          r_im  <= bus.wdata[15:8];
          r_exl <= bus.wdata[1];
          r_ie  <= bus.wdata[0];
        end
        5'd13:   r_ipsw <= bus.wdata[9:8];
        5'd14:   r_epc  <= bus.wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.rdata = '0;
    case (bus.raddr)
      5'd8:    bus.rdata = r_badvaddr;
      5'd9:    bus.rdata = r_count;
      5'd11:   bus.rdata = r_compare;
      5'd12:   bus.rdata = w_status;
      5'd13:   bus.rdata = w_cause;
      5'd14:   bus.rdata = r_epc;
      default: bus.rdata = '0;
    endcase
  end

  assign bus.flush       = w_take_exc | w_take_int | w_take_eret;
  assign bus.flush_pc    = w_take_eret ? r_epc : EXC_VECTOR;
  assign bus.int_pending = w_int_pending;
  assign bus.status      = w_status;
  assign bus.cause       = w_cause;
  assign bus.epc         = r_epc;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: timer interrupt, exceptions, ERET,
// priority, Count wrap/write, Compare clear and hw_int synchronizer timing.
module tb_cp0_exc_ctrl;
  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  cp0_exc_ctrl_if #(.NUM_HW_INT(5)) bus ();

  cp0_exc_ctrl #(
    .NUM_HW_INT(5),
    .COUNT_DIV (2),
    .EXC_VECTOR(32'hBFC0_0380)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.valid        = 1'b0;
    bus.exc_valid    = 1'b0;
    bus.exc_code     = 5'd0;
    bus.exc_pc       = 32'd0;
    bus.exc_badvaddr = 32'd0;
    bus.exc_bd       = 1'b0;
    bus.eret         = 1'b0;
    bus.cur_pc       = 32'd0;
    bus.cur_bd       = 1'b0;
    bus.wen          = 1'b0;
    bus.waddr        = 5'd0;
    bus.wdata        = 32'd0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.valid = 1'b1;
    bus.wen   = 1'b1;
    bus.waddr = a;
    bus.wdata = d;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    bus.hw_int = '0;
    bus.raddr  = 5'd12;
    resetn     = 1'b0;

    // Reset state while reset is held
    #3;
    chk("rst_status", bus.status, 32'h0040_0000);
    chk("rst_cause", bus.cause, 32'h0);
    chk("rst_epc", bus.epc, 32'h0);
    chk("rst_flush", {31'd0, bus.flush}, 32'd0);
    chk("rst_intp", {31'd0, bus.int_pending}, 32'd0);
    chk("rst_rdata_status", bus.rdata, 32'h0040_0000);
    #9;
    resetn    = 1'b1;
    bus.raddr = 5'd9;

    tick();  // E1
    chk("count_e1", bus.rdata, 32'd0);
    tick();  // E2
    chk("count_e2", bus.rdata, 32'd1);
    chk("ti_after_reset_match", bus.cause, 32'h4000_8000);
    mtc0(5'd11, 32'd5);
    #1 chk("mtc0_noflush", {31'd0, bus.flush}, 32'd0);
    tick();  // E3
    chk("compare_clears_ti", bus.cause, 32'h0);
    mtc0(5'd12, 32'h0000_8001);
    tick();  // E4
    idle();
    chk("status_write", bus.status, 32'h0040_8001);
    chk("intp_before_match", {31'd0, bus.int_pending}, 32'd0);
    repeat (6) tick();  // E10
    chk("count_5", bus.rdata, 32'd5);
    chk("ti_not_yet", bus.cause, 32'h0);
    tick();  // E11
    chk("ti_set", bus.cause, 32'h4000_8000);
    chk("intp_timer", {31'd0, bus.int_pending}, 32'd1);
    chk("noflush_invalid", {31'd0, bus.flush}, 32'd0);

    // Take the timer interrupt
    bus.valid  = 1'b1;
    bus.cur_pc = 32'h8000_0200;
    #1;
    chk("int_flush", {31'd0, bus.flush}, 32'd1);
    chk("int_flush_pc", bus.flush_pc, 32'hBFC0_0380);
    tick();  // E12
    idle();
    chk("int_status", bus.status, 32'h0040_8003);
    chk("int_epc", bus.epc, 32'h8000_0200);
    chk("int_cause", bus.cause, 32'h4000_8000);
    chk("intp_exl_masks", {31'd0, bus.int_pending}, 32'd0);

    bus.valid = 1'b1;
    bus.eret  = 1'b1;
    #1 chk("eret1_flush_pc", bus.flush_pc, 32'h8000_0200);
    tick();  // E13
    idle();
    chk("eret1_status", bus.status, 32'h0040_8001);

    // Exception beats pending interrupt and a Status write
    bus.valid        = 1'b1;
    bus.exc_valid    = 1'b1;
    bus.exc_code     = 5'd4;
    bus.exc_bd       = 1'b1;
    bus.exc_pc       = 32'h8000_0104;
    bus.exc_badvaddr = 32'h0000_1233;
    bus.wen          = 1'b1;
    bus.waddr        = 5'd12;
    bus.wdata        = 32'h0;
    bus.raddr        = 5'd8;
    #1 chk("exc_flush_pc", bus.flush_pc, 32'hBFC0_0380);
    tick();  // E14
    idle();
    chk("exc_status", bus.status, 32'h0040_8003);
    chk("exc_epc", bus.epc, 32'h8000_0100);
    chk("exc_cause", bus.cause, 32'hC000_8010);
    chk("exc_badvaddr", bus.rdata, 32'h0000_1233);

    // Nested exception with EXL set
    bus.valid        = 1'b1;
    bus.exc_valid    = 1'b1;
    bus.exc_code     = 5'd12;
    bus.exc_pc       = 32'h8000_0300;
    bus.exc_badvaddr = 32'h0000_DEAD;
    tick();  // E15
    idle();
    chk("nest_cause", bus.cause, 32'hC000_8030);
    chk("nest_epc", bus.epc, 32'h8000_0100);
    chk("nest_badvaddr", bus.rdata, 32'h0000_1233);
    bus.valid = 1'b1;
    bus.eret  = 1'b1;
    #1 chk("eret2_flush_pc", bus.flush_pc, 32'h8000_0100);
    tick();  // E16
    idle();
    chk("eret2_status", bus.status, 32'h0040_8001);

    // Interrupt beats MTC0
    mtc0(5'd12, 32'h0);
    bus.cur_pc = 32'h8000_0400;
    bus.cur_bd = 1'b1;
    #1 chk("int_vs_mtc0_flush", {31'd0, bus.flush}, 32'd1);
    tick();  // E17
    idle();
    chk("int_vs_mtc0_status", bus.status, 32'h0040_8003);
    chk("int_bd_epc", bus.epc, 32'h8000_03FC);
    chk("int_bd_cause", bus.cause, 32'hC000_8000);
    mtc0(5'd12, 32'h0);
    #1 chk("mtc0_exl_noflush", {31'd0, bus.flush}, 32'd0);
    tick();  // E18
    idle();
    chk("status_cleared", bus.status, 32'h0040_0000);

    // Count wrap and write-over-increment
    bus.raddr = 5'd9;
    #1 chk("count_9", bus.rdata, 32'd9);
    mtc0(5'd9, 32'hFFFF_FFFF);
    tick();  // E19
    idle();
    chk("count_load", bus.rdata, 32'hFFFF_FFFF);
    tick();  // E20
    chk("count_hold", bus.rdata, 32'hFFFF_FFFF);
    tick();  // E21
    chk("count_wrap", bus.rdata, 32'd0);
    tick();  // E22: increment due next edge
    mtc0(5'd9, 32'd10);
    tick();  // E23
    idle();
    chk("count_write_wins", bus.rdata, 32'd10);
    tick();  // E24
    chk("count_presc_restart", bus.rdata, 32'd10);
    tick();  // E25
    chk("count_11", bus.rdata, 32'd11);

    // Compare rewrite on the match cycle
    mtc0(5'd11, 32'd13);
    tick();  // E26
    idle();
    chk("ti_cleared", {31'd0, bus.cause[30]}, 32'd0);
    repeat (3) tick();  // E29
    chk("count_13", bus.rdata, 32'd13);
    mtc0(5'd11, 32'd13);
    tick();  // E30
    idle();
    chk("ti_clear_wins", {31'd0, bus.cause[30]}, 32'd0);
    tick();  // E31
    chk("ti_rematch", bus.cause, 32'hC000_8000);

    // hw_int[0] single-cycle pulse through the synchronizer
    mtc0(5'd12, 32'h0000_0401);
    tick();  // E32
    idle();
    chk("status_im2", bus.status, 32'h0040_0401);
    chk("intp_im2_idle", {31'd0, bus.int_pending}, 32'd0);
    bus.hw_int = 5'b00001;
    tick();  // E33
    bus.hw_int = 5'b00000;
    chk("ip2_lat1", {31'd0, bus.cause[10]}, 32'd0);
    tick();  // E34
    chk("ip2_high", {31'd0, bus.cause[10]}, 32'd1);
    chk("intp_ip2", {31'd0, bus.int_pending}, 32'd1);
    tick();  // E35
    chk("ip2_low", {31'd0, bus.cause[10]}, 32'd0);
    chk("intp_ip2_low", {31'd0, bus.int_pending}, 32'd0);

    // Only Cause.IP[1:0] are software-writable; unimplemented address reads 0
    mtc0(5'd13, 32'hFFFF_FFFF);
    tick();  // E36
    idle();
    chk("cause_sw_write", bus.cause, 32'hC000_8300);
    bus.raddr = 5'd5;
    #1 chk("unimpl_read", bus.rdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
